// File: rtl/bmc_decoder_arbiter_pkg.sv
// Shared constants and types for the BMC decoder arbiter and the decoder users.
package bmc_decoder_arbiter_pkg;

  localparam int DEF_NB_SENSORS     = 4;
  localparam int DEF_BIT_CONSIDERED = 17;
  localparam int DEF_TS_WIDTH       = 24;
  localparam int DEF_ACK_TIMEOUT    = 7;
  localparam int SENSOR_ID_W        = 3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CAPTURE   = 3'd1,
    ST_CLEAR     = 3'd2,
    ST_WAIT_DROP = 3'd3,
    ST_OUTPUT    = 3'd4
  } arb_state_t;

  // Index width that never collapses to zero bits.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bmc_decoder_arbiter_picker.sv
// Round-robin priority picker: first request at or after rr_ptr, wrapping.
module rr_priority_picker
  import bmc_decoder_arbiter_pkg::*;
#(
  parameter int NB_SENSORS = DEF_NB_SENSORS,
  parameter int IDX_W      = idx_width(NB_SENSORS)
) (
  input  logic [NB_SENSORS-1:0] req,
  input  logic [IDX_W-1:0]      rr_ptr,
  output logic [NB_SENSORS-1:0] gnt,
  output logic [IDX_W-1:0]      gnt_idx,
  output logic                  gnt_valid
);

  logic [IDX_W:0] pos;

  // Walk offsets from farthest to nearest so the nearest request wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    pos       = '0;
    for (int k = NB_SENSORS - 1; k >= 0; k--) begin
      pos = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (pos >= (IDX_W+1)'(NB_SENSORS)) begin
        pos = pos - (IDX_W+1)'(NB_SENSORS);
      end
      if (req[pos[IDX_W-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = pos[IDX_W-1:0];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NB_SENSORS; gi++) begin : g_onehot
      assign gnt[gi] = gnt_valid && (gnt_idx == IDX_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/bmc_decoder_arbiter.sv
// Shares one word sink between several BMC decoder channels: round-robin grant,
// capture of {id, word, timestamp}, decoder clear with drop timeout, valid/ready output.
module bmc_decoder_arbiter
  import bmc_decoder_arbiter_pkg::*;
#(
  parameter int NB_SENSORS     = DEF_NB_SENSORS,
  parameter int BIT_CONSIDERED = DEF_BIT_CONSIDERED,
  parameter int TS_WIDTH       = DEF_TS_WIDTH,
  parameter int ACK_TIMEOUT    = DEF_ACK_TIMEOUT
) (
  input  logic                               clk_96MHz,
  input  logic                               reset_n,
  input  logic                               enable,
  input  logic [NB_SENSORS-1:0]              sensor_mask,
  input  logic [NB_SENSORS-1:0]              dec_availible,
  input  logic [NB_SENSORS*BIT_CONSIDERED-1:0] dec_data,
  input  logic [NB_SENSORS*TS_WIDTH-1:0]     dec_ts,
  output logic [NB_SENSORS-1:0]              dec_enabled,
  output logic [NB_SENSORS-1:0]              dec_clear,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [SENSOR_ID_W-1:0]             out_sensor_id,
  output logic [BIT_CONSIDERED-1:0]          out_data,
  output logic [TS_WIDTH-1:0]                out_ts,
  output logic                               ack_err,
  input  logic                               err_clear
);

  localparam int IDX_W = idx_width(NB_SENSORS);
  localparam int CNT_W = idx_width(ACK_TIMEOUT + 1);

  arb_state_t                state_reg, state_next;
  logic [IDX_W-1:0]          rr_ptr_reg;
  logic [IDX_W-1:0]          gnt_idx_reg;
  logic [NB_SENSORS-1:0]     gnt_onehot_reg;
  logic [CNT_W-1:0]          timeout_reg;
  logic [NB_SENSORS-1:0]     req;
  logic [NB_SENSORS-1:0]     pick_onehot;
  logic [IDX_W-1:0]          pick_idx;
  logic                      pick_valid;
  logic                      flag_now;
  logic [BIT_CONSIDERED-1:0] data_lane [NB_SENSORS];
  logic [TS_WIDTH-1:0]       ts_lane   [NB_SENSORS];

  genvar gi;
  generate
    for (gi = 0; gi < NB_SENSORS; gi++) begin : g_lanes
      assign data_lane[gi] = dec_data[gi*BIT_CONSIDERED +: BIT_CONSIDERED];
      assign ts_lane[gi]   = dec_ts[gi*TS_WIDTH +: TS_WIDTH];
    end
  endgenerate

  assign req      = dec_availible & sensor_mask & {NB_SENSORS{enable}};
  assign flag_now = dec_availible[gnt_idx_reg];

  rr_priority_picker #(
    .NB_SENSORS (NB_SENSORS),
    .IDX_W      (IDX_W)
  ) u_picker (
    .req        (req),
    .rr_ptr     (rr_ptr_reg),
    .gnt        (pick_onehot),
    .gnt_idx    (pick_idx),
    .gnt_valid  (pick_valid)
  );

  // State register.
  always_ff @(posedge clk_96MHz or negedge reset_n) begin
    if (!reset_n) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  // Next-state logic; a stuck flag still ends in OUTPUT once the counter expires.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:      if (pick_valid) state_next = ST_CAPTURE;
      ST_CAPTURE:   state_next = ST_CLEAR;
      ST_CLEAR:     state_next = ST_WAIT_DROP;
      ST_WAIT_DROP: if (!flag_now || (timeout_reg == '0)) state_next = ST_OUTPUT;
      ST_OUTPUT:    if (out_ready) state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; the clear goes out even if the mask dropped after grant.
  always_comb begin
    out_valid = (state_reg == ST_OUTPUT);
    dec_clear = (state_reg == ST_CLEAR) ? gnt_onehot_reg : '0;
  end

  // Grant, capture, timeout, error and enable registers.
  always_ff @(posedge clk_96MHz or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_reg     <= '0;
      gnt_idx_reg    <= '0;
      gnt_onehot_reg <= '0;
      timeout_reg    <= '0;
      out_sensor_id  <= '0;
      out_data       <= '0;
      out_ts         <= '0;
      ack_err        <= 1'b0;
      dec_enabled    <= '0;
    end else begin
      dec_enabled <= sensor_mask & {NB_SENSORS{enable}};

      if (state_reg == ST_IDLE && pick_valid) begin
        gnt_idx_reg    <= pick_idx;
        gnt_onehot_reg <= pick_onehot;
      end

      // Captured one cycle after the grant, so a decoder overwrite in between wins.
      if (state_reg == ST_CAPTURE) begin
        out_sensor_id <= SENSOR_ID_W'(gnt_idx_reg);
        out_data      <= data_lane[gnt_idx_reg];
        out_ts        <= ts_lane[gnt_idx_reg];
      end

      if (state_reg == ST_CLEAR) begin
        timeout_reg <= CNT_W'(ACK_TIMEOUT);
      end else if (state_reg == ST_WAIT_DROP && timeout_reg != '0) begin
        timeout_reg <= timeout_reg - CNT_W'(1);
      end

      if (err_clear) begin
        ack_err <= 1'b0;
      end else if (state_reg == ST_WAIT_DROP && flag_now && timeout_reg == '0) begin
        ack_err <= 1'b1;
      end

      if (state_reg == ST_OUTPUT && out_ready) begin
        rr_ptr_reg <= (gnt_idx_reg == IDX_W'(NB_SENSORS - 1)) ? '0 : gnt_idx_reg + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_bmc_decoder_arbiter.sv
// Self-checking bench for bmc_decoder_arbiter with a behavioural decoder model
// and a scoreboard of expected words.
module tb_bmc_decoder_arbiter;

  localparam int N  = 4;
  localparam int BC = 17;
  localparam int TW = 24;

  logic          clk_96MHz = 1'b0;
  logic          reset_n;
  logic          enable;
  logic [N-1:0]  sensor_mask;
  logic [N-1:0]  dec_availible;
  logic [N*BC-1:0] dec_data;
  logic [N*TW-1:0] dec_ts;
  logic [N-1:0]  dec_enabled;
  logic [N-1:0]  dec_clear;
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    out_sensor_id;
  logic [BC-1:0] out_data;
  logic [TW-1:0] out_ts;
  logic          ack_err;
  logic          err_clear;

  bmc_decoder_arbiter dut (
    .clk_96MHz     (clk_96MHz),
    .reset_n       (reset_n),
    .enable        (enable),
    .sensor_mask   (sensor_mask),
    .dec_availible (dec_availible),
    .dec_data      (dec_data),
    .dec_ts        (dec_ts),
    .dec_enabled   (dec_enabled),
    .dec_clear     (dec_clear),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_sensor_id (out_sensor_id),
    .out_data      (out_data),
    .out_ts        (out_ts),
    .ack_err       (ack_err),
    .err_clear     (err_clear)
  );

  always #5 clk_96MHz = ~clk_96MHz;

  typedef struct {
    logic [2:0]    id;
    logic [BC-1:0] data;
    logic [TW-1:0] ts;
  } exp_t;

  typedef struct {
    int            ch;
    logic [BC-1:0] data;
    logic [TW-1:0] ts;
    logic [N-1:0]  exp_clear;
    int            exp_lat;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[4];

  int total = 0;
  int bad   = 0;
  int words_seen = 0;
  int clear_cnt  = 0;
  logic [N-1:0] stuck = '0;

  logic          s_valid;
  logic [N-1:0]  s_clear;
  logic [2:0]    s_id;
  logic [BC-1:0] s_data;
  logic [TW-1:0] s_ts;
  logic          s_err;
  logic [N-1:0]  s_en;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic set_lane(input int ch, input logic [BC-1:0] d, input logic [TW-1:0] t);
    dec_data[ch*BC +: BC] = d;
    dec_ts[ch*TW +: TW]   = t;
  endtask

  task automatic raise(input int ch, input logic [BC-1:0] d, input logic [TW-1:0] t, input bit expect_word);
    exp_t e;
    set_lane(ch, d, t);
    dec_availible[ch] = 1'b1;
    if (expect_word) begin
      e.id = 3'(ch); e.data = d; e.ts = t;
      exp_q.push_back(e);
    end
  endtask

  // One clock: sample on the falling edge, score any handshake, then let the
  // decoder model drop the flag of a channel it saw cleared.
  task automatic tick();
    exp_t e;
    @(negedge clk_96MHz);
    s_valid = out_valid; s_clear = dec_clear; s_id = out_sensor_id;
    s_data = out_data; s_ts = out_ts; s_err = ack_err; s_en = dec_enabled;
    if (s_clear != '0) clear_cnt++;
    if (s_valid && out_ready) begin
      words_seen++;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_unexpected: got id=%0d data=%0h expected no word", s_id, s_data);
      end else begin
        e = exp_q.pop_front();
        $display("word id=%0d data=%05h ts=%06h (expected id=%0d data=%05h ts=%06h)",
                 s_id, s_data, s_ts, e.id, e.data, e.ts);
        check("sb_id", 64'(s_id), 64'(e.id));
        check("sb_data", 64'(s_data), 64'(e.data));
        check("sb_ts", 64'(s_ts), 64'(e.ts));
      end
    end
    @(posedge clk_96MHz);
    #1;
    for (int i = 0; i < N; i++) begin
      if (s_clear[i] && !stuck[i]) dec_availible[i] = 1'b0;
    end
  endtask

  task automatic wait_words(input int target, input int budget, input string name);
    int k = 0;
    while (words_seen < target && k < budget) begin
      tick();
      k++;
    end
    check(name, 64'(words_seen >= target), 64'd1);
  endtask

  initial begin
    int k, lat, clr_k, err_k, base, c0;
    bit found, stable_ok, reraised;
    logic [2:0]    hold_id;
    logic [BC-1:0] hold_data;
    logic [TW-1:0] hold_ts;

    vecs[0] = '{2, 17'h1A5A5, 24'h00BEEF, 4'b0100, 4};
    vecs[1] = '{0, 17'h00001, 24'h000010, 4'b0001, 4};
    vecs[2] = '{1, 17'h10F0F, 24'hABCDEF, 4'b0010, 4};
    vecs[3] = '{3, 17'h1FFFF, 24'hFFFFFF, 4'b1000, 4};

    reset_n = 1'b0; enable = 1'b1; sensor_mask = '1; dec_availible = '0;
    dec_data = '0; dec_ts = '0; out_ready = 1'b1; err_clear = 1'b0;

    // Reset state
    repeat (2) @(posedge clk_96MHz);
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_enabled", 64'(dec_enabled), 64'd0);
    check("rst_clear", 64'(dec_clear), 64'd0);
    check("rst_id_data_ts", {out_sensor_id, out_data, out_ts}, 64'd0);
    check("rst_err", 64'(ack_err), 64'd0);
    @(negedge clk_96MHz);
    reset_n = 1'b1;
    @(posedge clk_96MHz);
    #1;
    tick();
    check("en_after_rst", 64'(s_en), 64'hF);

    // Single-channel table: latency, clear pattern and one-cycle valid pulse
    for (int v = 0; v < 4; v++) begin
      raise(vecs[v].ch, vecs[v].data, vecs[v].ts, 1'b1);
      k = 0; found = 0; lat = -1; clr_k = -1;
      while (!found && k < 20) begin
        tick();
        if (s_clear != '0) begin
          check("tbl_clear", 64'(s_clear), 64'(vecs[v].exp_clear));
          clr_k = k;
        end
        if (s_valid) begin found = 1; lat = k; end
        k++;
      end
      check("tbl_clear_cycle", 64'(clr_k), 64'd2);
      check("tbl_latency", 64'(lat), 64'(vecs[v].exp_lat));
      tick();
      check("tbl_valid_pulse", 64'(s_valid), 64'd0);
    end

    // Round robin from rr_ptr=0 over 4'b1011, ch0 re-raised after its service
    base = words_seen; reraised = 0; k = 0;
    raise(0, 17'h00A00, 24'h000A00, 1'b1);
    raise(1, 17'h00B11, 24'h000B11, 1'b1);
    raise(3, 17'h00D33, 24'h000D33, 1'b1);
    while (words_seen < base + 4 && k < 80) begin
      if (words_seen == base + 1 && !reraised) begin
        raise(0, 17'h0EEEE, 24'h0E0E0E, 1'b1);
        reraised = 1;
      end
      tick();
      k++;
    end
    check("rr_done", 64'(words_seen - base), 64'd4);
    check("rr_queue_empty", 64'(exp_q.size()), 64'd0);

    // Backpressure: word held stable, no further clears, next grant after accept
    out_ready = 1'b0;
    base = words_seen;
    raise(1, 17'h11111, 24'h111111, 1'b1);
    raise(2, 17'h02222, 24'h222222, 1'b1);
    k = 0; found = 0;
    while (!found && k < 20) begin tick(); found = s_valid; k++; end
    check("bp_reach_valid", 64'(found), 64'd1);
    hold_id = s_id; hold_data = s_data; hold_ts = s_ts;
    check("bp_id", 64'(hold_id), 64'd1);
    set_lane(1, 17'h05555, 24'h555555);
    c0 = clear_cnt; stable_ok = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!s_valid || s_id != hold_id || s_data != hold_data || s_ts != hold_ts) stable_ok = 0;
    end
    check("bp_stable", 64'(stable_ok), 64'd1);
    check("bp_no_clear", 64'(clear_cnt - c0), 64'd0);
    out_ready = 1'b1;
    tick();
    check("bp_accept_first", 64'(words_seen - base), 64'd1);
    wait_words(base + 2, 20, "bp_next_grant");

    // Stuck flag on ch1: error after the timeout, word still delivered
    stuck[1] = 1'b1;
    raise(1, 17'h13579, 24'h024680, 1'b1);
    k = 0; found = 0; lat = -1; err_k = -1;
    while (!found && k < 30) begin
      tick();
      if (s_err && err_k < 0) err_k = k;
      if (s_valid) begin found = 1; lat = k; end
      k++;
    end
    check("stuck_valid_cycle", 64'(lat), 64'd11);
    check("stuck_err_cycle", 64'(err_k), 64'd11);
    dec_availible[1] = 1'b0;
    stuck[1] = 1'b0;
    tick();
    check("stuck_err_sticky", 64'(s_err), 64'd1);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    tick();
    check("err_cleared", 64'(s_err), 64'd0);

    // Mask and enable
    sensor_mask = 4'b0001;
    base = words_seen; c0 = clear_cnt; found = 0;
    raise(3, 17'h03333, 24'h333333, 1'b0);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (s_valid) found = 1;
    end
    check("mask_no_grant", 64'(found), 64'd0);
    check("mask_no_clear", 64'(clear_cnt - c0), 64'd0);
    check("mask_enabled", 64'(s_en), 64'h1);
    enable = 1'b0;
    tick();
    tick();
    check("enable_off", 64'(s_en), 64'h0);
    enable = 1'b1; sensor_mask = '1;
    raise(3, 17'h03333, 24'h333333, 1'b1);
    wait_words(base + 1, 20, "unmask_grant");

    // Asynchronous reset while a word waits in OUTPUT
    out_ready = 1'b0;
    raise(0, 17'h0AAAA, 24'h0AAAAA, 1'b0);
    raise(2, 17'h0CCCC, 24'h0CCCCC, 1'b0);
    k = 0; found = 0;
    while (!found && k < 20) begin tick(); found = s_valid; k++; end
    check("rst6_reach_valid", 64'(found), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rst6_valid", 64'(out_valid), 64'd0);
    check("rst6_outs", {out_sensor_id, out_data, out_ts}, 64'd0);
    check("rst6_enabled", 64'(dec_enabled), 64'd0);
    check("rst6_clear", 64'(dec_clear), 64'd0);
    repeat (3) @(posedge clk_96MHz);
    @(negedge clk_96MHz);
    reset_n = 1'b1;
    @(posedge clk_96MHz);
    #1;
    base = words_seen;
    raise(2, 17'h0CCCC, 24'h0CCCCC, 1'b1);
    out_ready = 1'b1;
    wait_words(base + 1, 20, "rst6_regrant");
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
